// File: rtl/hd44780_byte_sender.sv
// HD44780 4-bit bus sender: one byte as two timed nybble strobes plus hold-off.
// Optional overrun flag built only when H4BS_OVERRUN_EN is defined.
module hd44780_byte_sender #(
   parameter int TICKS_TAS   = 3,
   parameter int TICKS_PWEH  = 22,
   parameter int TICKS_TCYCE = 48,
   parameter int TICKS_POST  = 2544,
   parameter int COUNT_BITS  = 12
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       STB_I,
   input  logic [7:0] i_data,
   input  logic       i_rs,
   input  logic       i_nybble_only,
   output logic       busy,
   output logic       error,
   output logic [3:0] o_lcd_nybble,
   output logic       o_rs,
   output logic       o_e
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EHIGH,
      S_ELOW,
      S_POST
   } state_t;

   localparam logic [COUNT_BITS-1:0] LD_TAS  = COUNT_BITS'(TICKS_TAS - 1);
   localparam logic [COUNT_BITS-1:0] LD_PWEH = COUNT_BITS'(TICKS_PWEH - 1);
   localparam logic [COUNT_BITS-1:0] LD_LOW  =
      COUNT_BITS'(TICKS_TCYCE - TICKS_TAS - TICKS_PWEH - 1);
   localparam logic [COUNT_BITS-1:0] LD_POST = COUNT_BITS'(TICKS_POST - 1);
   localparam logic [COUNT_BITS-1:0] ONE     = COUNT_BITS'(1);

   state_t                state_q, state_d;
   logic [COUNT_BITS-1:0] cnt_q, cnt_d;
   logic [3:0]            nyb_q, nyb_d;
   logic [3:0]            lo_q, lo_d;
   logic                  rs_q, rs_d;
   logic                  only_q, only_d;
   logic                  phase_q, phase_d;
   logic                  e_q, e_d;
   logic                  last;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         nyb_q   <= '0;
         lo_q    <= '0;
         rs_q    <= 1'b0;
         only_q  <= 1'b0;
         phase_q <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nyb_q   <= nyb_d;
         lo_q    <= lo_d;
         rs_q    <= rs_d;
         only_q  <= only_d;
         phase_q <= phase_d;
         e_q     <= e_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nyb_d   = nyb_q;
      lo_d    = lo_q;
      rs_d    = rs_q;
      only_d  = only_q;
      phase_d = phase_q;
      e_d     = e_q;
      last    = (cnt_q == '0);
      unique case (state_q)
         S_IDLE: begin
            if (STB_I) begin
               state_d = S_SETUP;
               cnt_d   = LD_TAS;
               nyb_d   = i_data[7:4];
               lo_d    = i_data[3:0];
               rs_d    = i_rs;
               only_d  = i_nybble_only;
               phase_d = 1'b0;
            end
         end
         S_SETUP: begin
            if (last) begin
               state_d = S_EHIGH;
               cnt_d   = LD_PWEH;
               e_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_EHIGH: begin
            if (last) begin
               state_d = S_ELOW;
               cnt_d   = LD_LOW;
               e_d     = 1'b0;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_ELOW: begin
            // Low nybble is put on the bus only after E has been low a full tail.
            if (last && !phase_q && !only_q) begin
               state_d = S_SETUP;
               cnt_d   = LD_TAS;
               nyb_d   = lo_q;
               phase_d = 1'b1;
            end else if (last) begin
               state_d = S_POST;
               cnt_d   = LD_POST;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_POST: begin
            if (last) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef H4BS_OVERRUN_EN
   logic err_q;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         err_q <= 1'b0;
      end else if (STB_I && (state_q != S_IDLE)) begin
         err_q <= 1'b1;
      end
   end

   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   assign busy         = (state_q != S_IDLE);
   assign o_lcd_nybble = nyb_q;
   assign o_rs         = rs_q;
   assign o_e          = e_q;

endmodule

// File: tb/tb_hd44780_byte_sender.sv
// Scoreboard bench for hd44780_byte_sender with randomized byte traffic.
// Expected pulses and busy lengths come from a byte-level model.
module tb_hd44780_byte_sender;

   localparam int TAS   = 2;
   localparam int PWEH  = 4;
   localparam int TCYCE = 10;
   localparam int POST  = 20;
   localparam int TMO   = 2000;
`ifdef H4BS_OVERRUN_EN
   localparam logic EXP_OVR = 1'b1;
`else
   localparam logic EXP_OVR = 1'b0;
`endif

   typedef struct {
      logic [3:0] nyb;
      logic       rs;
      bit         second;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       stb;
   logic [7:0] data;
   logic       rs_in;
   logic       only_in;
   logic       busy;
   logic       error;
   logic [3:0] nyb;
   logic       o_rs;
   logic       o_e;

   exp_t exp_q[$];
   int   busy_q[$];
   int   n_chk;
   int   n_fail;
   int   last_gap;
   bit   stray_done;

   hd44780_byte_sender #(
      .TICKS_TAS  (TAS),
      .TICKS_PWEH (PWEH),
      .TICKS_TCYCE(TCYCE),
      .TICKS_POST (POST),
      .COUNT_BITS (12)
   ) dut (
      .CLK_I        (clk),
      .RST_I        (rst),
      .STB_I        (stb),
      .i_data       (data),
      .i_rs         (rs_in),
      .i_nybble_only(only_in),
      .busy         (busy),
      .error        (error),
      .o_lcd_nybble (nyb),
      .o_rs         (o_rs),
      .o_e          (o_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every E rise and every busy fall.
   logic       pe, pb, pr;
   logic [3:0] pn;
   int         stab, bcnt, wcnt, lowcnt;

   always @(negedge clk) begin
      exp_t e;
      bit   chg;
      if (rst) begin
         pe = 1'b0;
         pb = 1'b0;
         pn = nyb;
         pr = o_rs;
         stab = 0;
         bcnt = 0;
         wcnt = 0;
         lowcnt = 0;
      end else begin
         chg = (nyb !== pn) || (o_rs !== pr);
         stab = chg ? 0 : stab + 1;
         if (busy) bcnt++;
         if (o_e && !pe) begin
            wcnt = 1;
            if (exp_q.size() == 0) begin
               chk("unexpected E pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("nybble", nyb, e.nyb);
               chk("rs", o_rs, e.rs);
               chk("rise latency", bcnt,
                   e.second ? TCYCE + TAS + 1 : TAS + 1);
               chk("setup stable", stab >= TAS, 1);
            end
         end else if (o_e) begin
            wcnt++;
            chk("hold while E high", chg, 0);
         end else if (pe) begin
            chk("E width", wcnt, PWEH);
            chk("change on E fall", chg, 0);
         end
         if (!busy && pb) begin
            if (busy_q.size() == 0) chk("unexpected busy end", 1, 0);
            else chk("busy length", bcnt, busy_q.pop_front());
            bcnt = 0;
            lowcnt = 0;
         end
         if (!busy) lowcnt++;
         if (busy && !pb) last_gap = lowcnt;
         pe = o_e;
         pb = busy;
         pn = nyb;
         pr = o_rs;
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (busy !== 1'b0 && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (t >= TMO) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle timeout: busy stuck at %b", busy);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic r,
                       input logic only);
      wait_idle();
      exp_q.push_back(exp_t'{d[7:4], r, 1'b0});
      if (!only) exp_q.push_back(exp_t'{d[3:0], r, 1'b1});
      busy_q.push_back(only ? TCYCE + POST : 2 * TCYCE + POST);
      stb = 1'b1;
      data = d;
      rs_in = r;
      only_in = only;
      @(negedge clk);
      stb = 1'b0;
      data = 8'($urandom);
      rs_in = 1'($urandom);
      only_in = 1'($urandom);
   endtask

   task automatic stray();
      if (busy === 1'b1) begin
         stb = 1'b1;
         stray_done = 1'b1;
         @(negedge clk);
         stb = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t expected earlier finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      last_gap = 0;
      stray_done = 1'b0;
      rst = 1'b1;
      stb = 1'b0;
      data = '0;
      rs_in = 1'b0;
      only_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset o_e", o_e, 0);
      chk("reset nybble", nyb, 0);
      chk("reset rs", o_rs, 0);
      chk("reset error", error, 0);
      rst = 1'b0;
      @(negedge clk);

      send(8'h48, 1'b1, 1'b0);
      send(8'h30, 1'b0, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("nybble held in idle", nyb, 4'h3);

      send(8'h41, 1'b0, 1'b0);
      send(8'h42, 1'b1, 1'b0);
      @(negedge clk);
      chk("back-to-back gap", last_gap, 1);

      send(8'h48, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      stray();
      wait_idle();
      chk("overrun error", error, EXP_OVR);
      send(8'h12, 1'b0, 1'b0);
      wait_idle();
      chk("error sticky", error, EXP_OVR);

      stray_done = 1'b0;
      send(8'h48, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("pre-reset E high", o_e, 1);
      rst = 1'b1;
      stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      chk("mid reset o_e", o_e, 0);
      chk("mid reset busy", busy, 0);
      chk("mid reset nybble", nyb, 0);
      chk("mid reset rs", o_rs, 0);
      chk("mid reset error", error, 0);
      exp_q.delete();
      busy_q.delete();
      rst = 1'b0;
      @(negedge clk);
      send(8'h55, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         send(8'($urandom), 1'($urandom), ($urandom_range(3) == 0));
         if (i == 0 || $urandom_range(1) == 1) begin
            repeat ($urandom_range(15)) @(negedge clk);
            stray();
         end
         if ($urandom_range(1) == 1) begin
            wait_idle();
            repeat ($urandom_range(3)) @(negedge clk);
         end
      end

      wait_idle();
      repeat (3) @(negedge clk);
      chk("pulses left in scoreboard", exp_q.size(), 0);
      chk("busy spans left", busy_q.size(), 0);
      chk("final error", error, EXP_OVR & stray_done);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
